pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised program-counter unit for the MIPS-style datapath.
- Successor to the combinational next-PC selector. Adds:
  - registered PC state;
  - stall and halt control;
  - a return-address stack (RAS) for call/return;
  - resolved branch selection with no latching or undefined holds.
- Sits between control unit/ALU zero flag and instruction memory address input.

Parameters:
- WIDTH, 32, PC and target width in bits.
- RESET_ADDR, 0, PC value loaded on reset.
- INC, 1, sequential increment (word-addressed instruction memory).
- RAS_DEPTH, 4, return-address stack entries, power of two, >=2.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  advance PC this cycle; low = stall, all state holds.
- control  in  3  next-PC mode: 000 seq/branch, 001 jump, 010 hold, 011 jump-reg, 100 call, 101 return, 11x reserved (treated as seq).
- brancheq  in  1  beq instruction.
- branchneq  in  1  bne instruction.
- zero  in  1  ALU zero flag.
- branch_target  in  WIDTH  PC-relative branch target (precomputed sum).
- jump_target  in  WIDTH  absolute jump/call target.
- reg_target  in  WIDTH  register operand for jr.
- halt_req  in  1  enter HALT at next enabled edge.
- resume  in  1  leave HALT.
- pc  out  WIDTH  current PC (registered).
- pc_next  out  WIDTH  combinational next PC for current inputs.
- halted  out  1  high in HALT.
- ras_empty  out  1  stack has 0 entries.
- ras_full  out  1  stack has RAS_DEPTH entries.
- ras_err  out  1  sticky: overflow or underflow occurred.

Behaviour:
- Reset (async, reset_n low), immediate and held while low:
  - pc = RESET_ADDR; state = BOOT; halted = 0.
  - RAS count = 0, ras_empty = 1, ras_full = 0, ras_err = 0.
- States: BOOT, RUN, HALT.
  - BOOT: pc holds RESET_ADDR for exactly one clock (instruction memory latency), then RUN unconditionally. enable is ignored in BOOT.
  - RUN: on a rising edge with enable = 1:
    - pc <= pc_next;
    - RAS updates per mode;
    - if halt_req = 1, go to HALT. The pc update still occurs on that same edge.
  - HALT: halted = 1; pc and RAS frozen; control inputs ignored. resume = 1 returns to RUN on the next edge; pc is unchanged by the transition.
- enable = 0 in RUN: pc, RAS and state all hold; pc_next still evaluates.
- pc_next, by control:
  - 000:
    - branchneq & ~zero -> branch_target.
    - brancheq & zero -> branch_target.
    - Every other combination, including both branch flags high or neither -> pc + INC.
  - 001: jump_target.
  - 010: pc.
  - 011: reg_target.
  - 100: jump_target; push pc + INC.
  - 101: RAS top; pop. If the RAS is empty -> reg_target, no pop, ras_err set.
  - 11x: as 000.
- Arithmetic: pc + INC is modulo 2^WIDTH. All-ones + 1 wraps to 0 silently.
- RAS is a circular buffer with top pointer and count:
  - Push when full: overwrite the oldest entry; count stays RAS_DEPTH; ras_err set.
  - Pop decrements count; the entry below becomes the top.
  - Push and pop never coincide (mode-exclusive).
- ras_err clears only on reset.
- Reset asserted mid-operation overrides all states immediately.

Test Plan:
- Reset release -> pc = 0 for two cycles (reset, BOOT); with control = 000 and no branch flags, pc = 1, 2, 3 on successive edges.
- pc = 10, control = 000, brancheq = 1, zero = 1, branch_target = 40 -> pc = 40. Same inputs with zero = 0 -> pc = 11. branchneq = 1 with zero = 0 -> 40. Both flags high -> 11.
- pc = 5, call to jump_target = 100 -> pc = 100, RAS top = 6. Then return -> pc = 6, ras_empty = 1, ras_err = 0.
- Five calls with RAS_DEPTH = 4 -> ras_full = 1, ras_err = 1. Four returns yield the last four pushed addresses in LIFO order. A fifth return with reg_target = 77 -> pc = 77.
- enable = 0 for 3 cycles at pc = 20 -> pc stays 20. halt_req at pc = 20 -> pc = 21 and halted = 1. It holds 21 through any control until resume; the next enabled edge advances to 22.
- WIDTH = 8, pc = 255, control = 000 -> pc = 0. Assert reset_n low mid-HALT -> pc = 0, halted = 0 without any clock edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter unit for a MIPS-style datapath. Holds the registered PC,
// selects the next PC from sequential / branch / jump / jr / call / return
// modes, and keeps a small circular return-address stack (RAS) for
// call/return pairs.
//
// Lifecycle: after reset the unit spends one clock in BOOT (PC held at
// RESET_ADDR while instruction memory produces the first word), then RUN.
// In RUN an edge with enable=1 commits pc_next and the RAS update; halt_req
// on such an edge moves to HALT after that commit. HALT freezes everything
// until resume.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   enable                advance this cycle (0 = stall, all state holds)
//   control[2:0]          next-PC mode (000 seq/branch, 001 jump, 010 hold,
//                         011 jr, 100 call, 101 return, 11x as 000)
//   brancheq, branchneq   beq / bne instruction flags
//   zero                  ALU zero flag
//   branch_target         precomputed PC-relative branch target
//   jump_target           absolute jump / call target
//   reg_target            register operand for jr (and empty-stack return)
//   halt_req, resume      enter / leave HALT
//   pc                    current PC (registered)
//   pc_next               combinational next PC for the current inputs
//   halted                high while in HALT
//   ras_empty, ras_full   stack occupancy flags
//   ras_err               sticky overflow/underflow flag, cleared by reset
//   state_dbg             raw FSM state for observation
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int                RAS_DEPTH  = 4,
    parameter int                WIDTH      = 32,
    parameter logic [WIDTH-1:0]  RESET_ADDR = '0,
    parameter logic [WIDTH-1:0]  INC        = WIDTH'(1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [2:0]       control,
    input  logic             brancheq,
    input  logic             branchneq,
    input  logic             zero,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] reg_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next,
    output logic             halted,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err,
    output logic [1:0]       state_dbg
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [2:0] C_JUMP   = 3'b001;
    localparam logic [2:0] C_HOLD   = 3'b010;
    localparam logic [2:0] C_JR     = 3'b011;
    localparam logic [2:0] C_CALL   = 3'b100;
    localparam logic [2:0] C_RETURN = 3'b101;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]   ras_q [RAS_DEPTH];
    logic [WIDTH-1:0]   ras_d [RAS_DEPTH];
    logic [PTR_W-1:0]   top_q, top_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]   pc_inc;
    logic [WIDTH-1:0]   pc_next_c;
    logic [PTR_W-1:0]   push_ptr;
    logic               br_taken;
    logic               stk_empty;
    logic               stk_full;

    // Modulo 2^WIDTH by construction: the sum is truncated to WIDTH bits.
    assign pc_inc    = pc_q + INC;
    assign push_ptr  = top_q + PTR_W'(1);
    assign stk_empty = (cnt_q == '0);
    assign stk_full  = (cnt_q == CNT_W'(RAS_DEPTH));

    // A branch is taken only when exactly one branch flag is set and its
    // condition holds; both flags together decode as "no branch".
    assign br_taken = (brancheq & ~branchneq & zero) |
                      (branchneq & ~brancheq & ~zero);

    always_comb begin
        pc_next_c = pc_inc;
        case (control)
            C_JUMP:   pc_next_c = jump_target;
            C_HOLD:   pc_next_c = pc_q;
            C_JR:     pc_next_c = reg_target;
            C_CALL:   pc_next_c = jump_target;
            // Returning with nothing on the stack falls back to the register
            // operand so software can recover with a plain jr-style address.
            C_RETURN: pc_next_c = stk_empty ? reg_target : ras_q[top_q];
            default:  pc_next_c = br_taken ? branch_target : pc_inc;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ras_d   = ras_q;
        top_d   = top_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (enable) begin
                    pc_d = pc_next_c;
                    if (control == C_CALL) begin
                        // Advancing the top pointer onto the oldest slot when
                        // full is what makes an overflow overwrite it.
                        top_d           = push_ptr;
                        ras_d[push_ptr] = pc_inc;
                        if (stk_full) begin
                            err_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (control == C_RETURN) begin
                        if (stk_empty) begin
                            err_d = 1'b1;
                        end else begin
                            top_d = top_q - PTR_W'(1);
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    if (halt_req) begin
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT: begin
                if (resume) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_ADDR;
            top_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ras_q   <= ras_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign pc        = pc_q;
    assign pc_next   = pc_next_c;
    assign halted    = (state_q == S_HALT);
    assign ras_empty = stk_empty;
    assign ras_full  = stk_full;
    assign ras_err   = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed scenarios followed by a random phase, all checked against a
// behavioural model: the PC is an integer-like value, the return-address
// stack is a queue (oldest entry dropped on overflow), and the lifecycle is a
// small boot/run/halt variable. Expected PCs are queued in exp_q when the
// model commits an edge and popped after the DUT edge.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;
    localparam int W = 8;
    localparam int D = 4;

    // ---------------- clock / reset ----------------
    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic [2:0]   control = 3'd0;
    logic         brancheq = 1'b0;
    logic         branchneq = 1'b0;
    logic         zero = 1'b0;
    logic [W-1:0] branch_target = '0;
    logic [W-1:0] jump_target = '0;
    logic [W-1:0] reg_target = '0;
    logic         halt_req = 1'b0;
    logic         resume = 1'b0;
    logic [W-1:0] pc;
    logic [W-1:0] pc_next;
    logic         halted;
    logic         ras_empty;
    logic         ras_full;
    logic         ras_err;
    logic [1:0]   state_dbg;

    always #5 clock = ~clock;

    pc_sequencer #(
        .RAS_DEPTH (D),
        .WIDTH     (W),
        .RESET_ADDR(8'd0),
        .INC       (8'd1)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .control      (control),
        .brancheq     (brancheq),
        .branchneq    (branchneq),
        .zero         (zero),
        .branch_target(branch_target),
        .jump_target  (jump_target),
        .reg_target   (reg_target),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc           (pc),
        .pc_next      (pc_next),
        .halted       (halted),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full),
        .ras_err      (ras_err),
        .state_dbg    (state_dbg)
    );

    // ---------------- reference model ----------------
    int           n_vec = 0;
    int           n_err = 0;
    int           m_mode;         // 0 = boot, 1 = run, 2 = halt
    logic [W-1:0] m_pc;
    logic [W-1:0] m_stack[$];     // back = most recent call
    logic         m_err;
    logic [W-1:0] exp_q[$];

    task automatic m_reset();
        m_mode = 0;
        m_pc   = '0;
        m_stack.delete();
        m_err  = 1'b0;
        exp_q.delete();
    endtask

    function automatic logic [W-1:0] model_next();
        logic [W-1:0] seq;
        logic         taken;
        seq   = m_pc + 8'd1;
        taken = (brancheq && !branchneq && zero) || (branchneq && !brancheq && !zero);
        case (control)
            3'd1:    return jump_target;
            3'd2:    return m_pc;
            3'd3:    return reg_target;
            3'd4:    return jump_target;
            3'd5:    return (m_stack.size() == 0) ? reg_target : m_stack[$];
            default: return taken ? branch_target : seq;
        endcase
    endfunction

    task automatic model_edge();
        logic [W-1:0] nxt;
        logic [W-1:0] dropped;
        nxt = model_next();
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (enable) begin
                if (control == 3'd4) begin
                    m_stack.push_back(m_pc + 8'd1);
                    if (m_stack.size() > D) begin
                        dropped = m_stack.pop_front();
                        m_err   = 1'b1;
                    end
                end else if (control == 3'd5) begin
                    if (m_stack.size() == 0) m_err = 1'b1;
                    else dropped = m_stack.pop_back();
                end
                m_pc = nxt;
                if (halt_req) m_mode = 2;
            end
        end else begin
            if (resume) m_mode = 1;
        end
        exp_q.push_back(m_pc);
    endtask

    // ---------------- scoreboard checks ----------------
    task automatic check_v(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_status();
        check_b("halted", halted, m_mode == 2);
        check_b("ras_empty", ras_empty, m_stack.size() == 0);
        check_b("ras_full", ras_full, m_stack.size() == D);
        check_b("ras_err", ras_err, m_err);
    endtask

    // ---------------- driver tasks ----------------
    // Entered just after a rising edge; leaves just after the next one.
    task automatic step();
        logic [W-1:0] e;
        #1;
        if (m_mode == 1) check_v("pc_next", pc_next, model_next());
        model_edge();
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check_v("pc", pc, e);
        check_status();
    endtask

    task automatic set_in(input logic [2:0] c, input logic beq, input logic bne,
                          input logic z, input logic [W-1:0] bt,
                          input logic [W-1:0] jt, input logic [W-1:0] rt);
        control       = c;
        brancheq      = beq;
        branchneq     = bne;
        zero          = z;
        branch_target = bt;
        jump_target   = jt;
        reg_target    = rt;
    endtask

    task automatic go(input logic [2:0] c, input logic [W-1:0] jt, input logic [W-1:0] rt);
        set_in(c, 1'b0, 1'b0, 1'b0, 8'd0, jt, rt);
        step();
    endtask

    task automatic branch_from_10(input logic beq, input logic bne, input logic z);
        go(3'd1, 8'd10, 8'd0);
        set_in(3'd0, beq, bne, z, 8'd40, 8'd0, 8'd0);
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        m_reset();
        #1;
        check_v("reset_pc", pc, 8'd0);
        check_status();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        enable  = 1'b1;

        // BOOT holds 0, then sequential 1, 2, 3
        for (int i = 0; i < 4; i++) go(3'd0, 8'd0, 8'd0);

        // branch decode from pc = 10
        branch_from_10(1'b1, 1'b0, 1'b1);   // -> 40
        branch_from_10(1'b1, 1'b0, 1'b0);   // -> 11
        branch_from_10(1'b0, 1'b1, 1'b0);   // -> 40
        branch_from_10(1'b1, 1'b1, 1'b0);   // -> 11
        branch_from_10(1'b1, 1'b1, 1'b1);   // -> 11
        go(3'd6, 8'd0, 8'd0);               // reserved mode behaves as seq

        // call / return pair
        go(3'd1, 8'd5, 8'd0);
        go(3'd4, 8'd100, 8'd0);             // -> 100, push 6
        go(3'd5, 8'd0, 8'd99);              // -> 6

        // overflow: five calls, four returns in LIFO order, then underflow
        for (int i = 0; i < 5; i++) go(3'd4, W'(50 + 10 * i), 8'd0);
        for (int i = 0; i < 4; i++) go(3'd5, 8'd0, 8'd0);
        go(3'd5, 8'd0, 8'd77);              // -> 77, underflow

        // stall, then halt
        go(3'd1, 8'd20, 8'd0);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) go(3'(i + 1), 8'd33, 8'd44);
        enable   = 1'b1;
        halt_req = 1'b1;
        go(3'd0, 8'd0, 8'd0);               // -> 21, halted
        halt_req = 1'b0;
        for (int i = 0; i < 3; i++) go(3'(i + 1), 8'd90, 8'd91);
        resume = 1'b1;
        go(3'd1, 8'd90, 8'd0);              // leaves HALT, pc stays 21
        resume = 1'b0;
        go(3'd0, 8'd0, 8'd0);               // -> 22

        // wrap at the top of the address space
        go(3'd1, 8'd255, 8'd0);
        go(3'd0, 8'd0, 8'd0);               // -> 0

        // random phase
        for (int i = 0; i < 400; i++) begin
            enable   = ($urandom_range(0, 7) != 0);
            halt_req = ($urandom_range(0, 15) == 0);
            resume   = ($urandom_range(0, 2) == 0);
            set_in(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                   W'($urandom_range(0, 255)));
            step();
        end

        // reset in the middle of HALT takes effect without a clock edge
        resume   = 1'b0;
        enable   = 1'b1;
        halt_req = 1'b1;
        go(3'd1, 8'd123, 8'd0);
        halt_req = 1'b0;
        go(3'd0, 8'd0, 8'd0);
        check_b("halt_before_reset", halted, 1'b1);
        #1;
        reset_n = 1'b0;
        m_reset();
        #1;
        check_v("async_reset_pc", pc, 8'd0);
        check_status();

        // release again and confirm the BOOT cycle repeats
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) go(3'd0, 8'd0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
